// File: rtl/vector_store_unit_if.sv
// Bus bundle between the vector store unit and its requester / BRAM write port.
// The master side issues store requests and watches the BRAM write stream.
// The slave side is the store unit itself.
interface vector_store_unit_if #(
   parameter int NoOfElem = 16,
   parameter int memDepth = 12,
   parameter int wordSize = 32
);

   // Request side: one full vector register plus its placement
   logic                               start;
   logic [memDepth-1:0]                baseAddr;
   logic [NoOfElem-1:0][wordSize-1:0]  vecIn;
   logic [NoOfElem-1:0]                elemMask;

   // BRAM write port and status
   logic [memDepth-1:0]                memAddr;
   logic [wordSize-1:0]                memDataOut;
   logic                               memWE;
   logic                               memEnable;
   logic                               busy;
   logic                               done;

   modport master (
      output start, baseAddr, vecIn, elemMask,
      input  memAddr, memDataOut, memWE, memEnable, busy, done
   );

   modport slave (
      input  start, baseAddr, vecIn, elemMask,
      output memAddr, memDataOut, memWE, memEnable, busy, done
   );

endinterface

// File: rtl/vector_store_unit.sv
// Vector store unit: captures one vector register and a base address, then
// streams the elements into BRAM one word per cycle at consecutive addresses.
// Masked-off elements still take their cycle so the store latency is fixed
// at NoOfElem+1 cycles of busy, which holds off the fetch unit's reads.
module vector_store_unit #(
   parameter int NoOfElem = 16,
   parameter int memDepth = 12,
   parameter int wordSize = 32
) (
   input  logic               clk,
   input  logic               RESET,
   vector_store_unit_if.slave bus
);

   localparam int              IdxW    = $clog2(NoOfElem);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NoOfElem - 1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } state_t;

   state_t                             state_q, state_d;
   logic [IdxW-1:0]                    idx_q, idx_d;
   logic [IdxW-1:0]                    idx_inc;

   // Private copies of the request; the requester may change its inputs
   // as soon as the store has been accepted.
   logic [NoOfElem-1:0][wordSize-1:0]  shadow_vec_q, shadow_vec_d;
   logic [NoOfElem-1:0]                shadow_mask_q, shadow_mask_d;
   logic [memDepth-1:0]                shadow_base_q, shadow_base_d;

   // Registered outputs: nothing reaches the BRAM port combinationally.
   logic [memDepth-1:0]                addr_q, addr_d;
   logic [wordSize-1:0]                data_q, data_d;
   logic                               we_q, we_d;
   logic                               en_q, en_d;
   logic                               busy_q, busy_d;
   logic                               done_q, done_d;

   assign idx_inc = idx_q + IdxW'(1);

   // Next-state and next-output decode for the store sequencer
   always_comb begin
      // NOTE: every variable gets a hold value before the case so that no
      // path through the decode leaves it unassigned (which would infer a latch).
      state_d       = state_q;
      idx_d         = idx_q;
      shadow_vec_d  = shadow_vec_q;
      shadow_mask_d = shadow_mask_q;
      shadow_base_d = shadow_base_q;
      addr_d        = addr_q;
      data_d        = data_q;
      we_d          = we_q;
      en_d          = en_q;
      busy_d        = busy_q;
      done_d        = done_q;

      case (state_q)
         IDLE: begin
            addr_d = '0;
            data_d = '0;
            we_d   = 1'b0;
            en_d   = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b0;
            if (bus.start) begin
               shadow_vec_d  = bus.vecIn;
               shadow_mask_d = bus.elemMask;
               shadow_base_d = bus.baseAddr;
               state_d       = WRITE;
               idx_d         = '0;
               // Element 0 goes out straight from the request inputs so the
               // first write lands in the cycle right after acceptance.
               addr_d        = bus.baseAddr;
               data_d        = bus.vecIn[0];
               we_d          = bus.elemMask[0];
               en_d          = 1'b1;
               busy_d        = 1'b1;
            end
         end

         WRITE: begin
            if (idx_q == LastIdx) begin
               state_d = DONE;
               we_d    = 1'b0;
               en_d    = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b1;
            end else begin
               idx_d  = idx_inc;
               // Address wraps silently at the top of the BRAM.
               addr_d = shadow_base_q + memDepth'(idx_inc);
               data_d = shadow_vec_q[idx_inc];
               we_d   = shadow_mask_q[idx_inc];
               en_d   = 1'b1;
               busy_d = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
            addr_d  = '0;
            data_d  = '0;
            we_d    = 1'b0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, shadow and output registers with asynchronous abort on RESET
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         // NOTE: the shadow copy is plain flops, not a RAM, so it is cleared
         // on reset like any other state and never leaks a stale vector.
         shadow_vec_q  <= '0;
         shadow_mask_q <= '0;
         shadow_base_q <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         we_q          <= 1'b0;
         en_q          <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, independent of statement order.
         state_q       <= state_d;
         idx_q         <= idx_d;
         shadow_vec_q  <= shadow_vec_d;
         shadow_mask_q <= shadow_mask_d;
         shadow_base_q <= shadow_base_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         we_q          <= we_d;
         en_q          <= en_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bus.memAddr    = addr_q;
   assign bus.memDataOut = data_q;
   assign bus.memWE      = we_q;
   assign bus.memEnable  = en_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_vector_store_unit.sv
// Testbench for vector_store_unit: a table of directed stores, an abort
// sequence, and randomized stores, all compared cycle by cycle against the
// expected write stream computed from the store rules.
module tb_vector_store_unit;

   localparam int N  = 16;
   localparam int AW = 12;
   localparam int W  = 32;

   typedef logic [N-1:0][W-1:0] vec_arr_t;

   typedef struct {
      logic [AW-1:0] base;
      logic [N-1:0]  mask;
      logic [W-1:0]  seed;
      bit            glitch;
      int            exp_writes;
      logic [AW-1:0] exp_last;
   } rec_t;

   logic clk;
   logic RESET;

   int n_cmp;
   int n_err;

   vector_store_unit_if #(.NoOfElem(N), .memDepth(AW), .wordSize(W)) bus ();

   vector_store_unit #(.NoOfElem(N), .memDepth(AW), .wordSize(W)) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {memEnable, memWE, busy, done, memAddr, memDataOut}
   function automatic logic [47:0] obs();
      return {bus.memEnable, bus.memWE, bus.busy, bus.done, bus.memAddr, bus.memDataOut};
   endfunction

   function automatic logic [3:0] obs_ctl();
      return {bus.memEnable, bus.memWE, bus.busy, bus.done};
   endfunction

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic scramble();
      bus.baseAddr = AW'($urandom);
      for (int k = 0; k < N; k++) bus.vecIn[k] = $urandom;
      bus.elemMask = N'($urandom);
   endtask

   // Issue one store from an IDLE negedge and follow it to the idle cycle
   // after done. Expected stream: element i at (base+i) mod 2^AW with
   // write enable mask[i], then one done cycle, then one idle cycle.
   task automatic run_store(input logic [AW-1:0] base, input vec_arr_t vec,
                            input logic [N-1:0] mask, input bit glitch,
                            input bit abort, output int nwr,
                            output logic [AW-1:0] last_addr);
      logic [AW-1:0] ea;
      nwr       = 0;
      last_addr = '0;
      bus.start    = 1'b1;
      bus.baseAddr = base;
      bus.vecIn    = vec;
      bus.elemMask = mask;
      @(negedge clk);
      bus.start = 1'b0;
      scramble();
      for (int i = 0; i < N; i++) begin
         ea = AW'((int'(base) + i) % (1 << AW));
         check($sformatf("elem%0d", i), obs(), {1'b1, mask[i], 1'b1, 1'b0, ea, vec[i]});
         if (bus.memWE) nwr++;
         last_addr = bus.memAddr;
         if (abort && i == 7) begin
            #2 RESET = 1'b0;
            #1 check("abort_async", obs(), 48'h0);
            @(negedge clk);
            check("abort_hold", obs(), 48'h0);
            RESET = 1'b1;
            @(negedge clk);
            check("abort_idle", {44'h0, obs_ctl()}, 48'h0);
            @(negedge clk);
            check("abort_no_done", {44'h0, obs_ctl()}, 48'h0);
            return;
         end
         if (glitch && i == 5) begin
            bus.start = 1'b1;
            scramble();
         end
         if (glitch && i == 6) bus.start = 1'b0;
         @(negedge clk);
      end
      check("done_cycle", {44'h0, obs_ctl()}, {44'h0, 4'b0011});
      @(negedge clk);
      check("idle_gap", {44'h0, obs_ctl()}, 48'h0);
   endtask

   rec_t tbl[6];

   initial begin
      vec_arr_t      v;
      int            nwr;
      logic [AW-1:0] la;
      logic [AW-1:0] rb;
      logic [N-1:0]  rm;

      n_cmp = 0;
      n_err = 0;

      tbl[0] = '{base: 12'h010, mask: 16'hFFFF, seed: 32'hA000_0000, glitch: 1'b0, exp_writes: 16, exp_last: 12'h01F};
      tbl[1] = '{base: 12'h100, mask: 16'h5555, seed: 32'hB000_0000, glitch: 1'b0, exp_writes: 8,  exp_last: 12'h10F};
      tbl[2] = '{base: 12'hFFE, mask: 16'hFFFF, seed: 32'hC000_0000, glitch: 1'b0, exp_writes: 16, exp_last: 12'h00D};
      tbl[3] = '{base: 12'h200, mask: 16'hFFFF, seed: 32'hD000_0000, glitch: 1'b1, exp_writes: 16, exp_last: 12'h20F};
      tbl[4] = '{base: 12'h000, mask: 16'h0000, seed: 32'hE000_0000, glitch: 1'b0, exp_writes: 0,  exp_last: 12'h00F};
      tbl[5] = '{base: 12'hFF8, mask: 16'h8001, seed: 32'h1234_5678, glitch: 1'b0, exp_writes: 2,  exp_last: 12'h007};

      RESET        = 1'b0;
      bus.start    = 1'b0;
      bus.baseAddr = '0;
      bus.vecIn    = '0;
      bus.elemMask = '0;
      #3 check("reset_state", obs(), 48'h0);
      repeat (2) @(negedge clk);
      RESET = 1'b1;
      @(negedge clk);
      check("idle_after_reset", obs(), 48'h0);

      // Directed table; consecutive stores are back-to-back through one idle cycle
      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < N; k++) v[k] = tbl[t].seed + W'(k);
         run_store(tbl[t].base, v, tbl[t].mask, tbl[t].glitch, 1'b0, nwr, la);
         check($sformatf("tbl%0d_writes", t), 48'(nwr), 48'(tbl[t].exp_writes));
         check($sformatf("tbl%0d_last_addr", t), 48'(la), 48'(tbl[t].exp_last));
      end

      // Reset at element 7, then a clean store from element 0
      for (int k = 0; k < N; k++) v[k] = 32'h5A00_0000 + W'(k);
      run_store(12'h300, v, 16'hFFFF, 1'b0, 1'b1, nwr, la);
      for (int k = 0; k < N; k++) v[k] = 32'h6B00_0000 + W'(k);
      run_store(12'h300, v, 16'hFFFF, 1'b0, 1'b0, nwr, la);
      check("post_abort_writes", 48'(nwr), 48'd16);

      // Randomized stores against the stream model
      for (int r = 0; r < 20; r++) begin
         rb = AW'($urandom);
         rm = N'($urandom);
         for (int k = 0; k < N; k++) v[k] = $urandom;
         run_store(rb, v, rm, 1'($urandom_range(0, 1)), 1'b0, nwr, la);
         check($sformatf("rnd%0d_writes", r), 48'(nwr), 48'($countones(rm)));
         check($sformatf("rnd%0d_last_addr", r), 48'(la),
               48'((int'(rb) + N - 1) % (1 << AW)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
